uart_echo: RTL

//  Byte-level client on the far side of the UART controller's parallel interface.

---
 rtl/uart_echo.sv | 135 +++++++++++++
 1 files changed

// File: rtl/uart_echo.sv
// Loopback responder: buffers bytes from the UART receive side and echoes them to the transmit side.
// Optional UART_ECHO_CASE_EN inverts ASCII letter case on the echoed bytes.
module uart_echo #(
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned AW       = 4,
    parameter int unsigned BUSY_TMO = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    rx_data,
    input  logic          rx_vld,
    input  logic          tx_rdy,
    input  logic          ovf_clr,
    output logic [7:0]    tx_data,
    output logic          tx_vld,
    output logic [AW:0]   fifo_cnt,
    output logic          overflow
);

    localparam int unsigned TW = $clog2(BUSY_TMO + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_BUSY,
        S_WAIT_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     cnt_q, cnt_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic [7:0]      tx_data_q, tx_data_d;
    logic            pop_q, pop_d;
    logic            tx_vld_q, tx_vld_d;
    logic            overflow_q, overflow_d;
    logic [7:0]      mem_q [DEPTH];
    logic            push, pop, drop;

    function automatic logic [7:0] echo_byte(input logic [7:0] b);
`ifdef UART_ECHO_CASE_EN
        if (((b >= 8'h41) && (b <= 8'h5A)) || ((b >= 8'h61) && (b <= 8'h7A))) begin
            return b ^ 8'h20;
        end
`endif
        return b;
    endfunction

    // Transmit pacing FSM; the popped byte is latched here and pulsed one cycle later.
    always_comb begin
        state_d   = state_q;
        tmo_d     = tmo_q;
        tx_data_d = tx_data_q;
        pop       = 1'b0;
        case (state_q)
            S_IDLE: begin
                tmo_d = '0;
                if ((cnt_q != '0) && tx_rdy) begin
                    pop       = 1'b1;
                    tx_data_d = echo_byte(mem_q[rd_ptr_q]);
                    state_d   = S_WAIT_BUSY;
                end
            end
            S_WAIT_BUSY: begin
                if (!tx_rdy) begin
                    state_d = S_WAIT_DONE;
                end else if (tmo_q == TW'(BUSY_TMO - 1)) begin
                    state_d = S_IDLE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            S_WAIT_DONE: begin
                if (tx_rdy) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FIFO bookkeeping; a pop in the same cycle frees the slot for a push into a full FIFO.
    always_comb begin
        push       = rx_vld && ((cnt_q != (AW+1)'(DEPTH)) || pop);
        drop       = rx_vld && !push;
        wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        cnt_d      = cnt_q;
        if (push && !pop) begin
            cnt_d = cnt_q + (AW+1)'(1);
        end else if (pop && !push) begin
            cnt_d = cnt_q - (AW+1)'(1);
        end
        pop_d      = pop;
        tx_vld_d   = pop_q;
        overflow_d = drop ? 1'b1 : (ovf_clr ? 1'b0 : overflow_q);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            tmo_q      <= '0;
            tx_data_q  <= 8'h00;
            pop_q      <= 1'b0;
            tx_vld_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            tmo_q      <= tmo_d;
            tx_data_q  <= tx_data_d;
            pop_q      <= pop_d;
            tx_vld_q   <= tx_vld_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage array carries no reset; occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= rx_data;
        end
    end

    assign tx_data  = tx_data_q;
    assign tx_vld   = tx_vld_q;
    assign fifo_cnt = cnt_q;
    assign overflow = overflow_q;

endmodule
